ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
//  Two-requester round-robin arbiter/sequencer in front of the single-port data RAM.
//  Port m0 is the CPU MEM stage; port m1 is the debug/loader port.
//  Latches one command, drives the RAM for exactly one cycle, captures read data,
//  then returns a one-cycle ack. All RAM-side outputs are registered.
// PARAMETERS
//  ADDR_WIDTH  32  byte-address width (RAM indexes word address addr[..:2])
//  DATA_WIDTH  32  data word width
//  SEL_WIDTH   4   byte write-enable width (DATA_WIDTH/8)
// PORTS
//  clk             in   1           clock; all state updates on posedge
//  rst             in   1           asynchronous, active-high reset
//  m0_req          in   1           m0 request; held with command stable until m0_ack
//  m0_write_en     in   SEL_WIDTH   m0 byte enables; 0 = read
//  m0_addr         in   ADDR_WIDTH  m0 byte address
//  m0_write_data   in   DATA_WIDTH  m0 store data
//  m0_ack          out  1           one-cycle completion pulse to m0
//  m0_read_data    out  DATA_WIDTH  m0 load data; valid with m0_ack, held until next m0 ack
//  m1_req/m1_write_en/m1_addr/m1_write_data/m1_ack/m1_read_data  same as m0, for m1
//  ram_en          out  1           RAM enable
//  ram_write_en    out  SEL_WIDTH   RAM byte write enables
//  ram_addr        out  ADDR_WIDTH  RAM address
//  ram_write_data  out  DATA_WIDTH  RAM store data
//  ram_read_data   in   DATA_WIDTH  RAM combinational read data (0 when disabled or writing)
// BEHAVIOUR
//  Reset: state=IDLE; ram_en, ram_write_en, ram_addr, ram_write_data = 0; m0_ack, m1_ack = 0;
//   m0_read_data, m1_read_data = 0; last_grant=1 (m0 wins first tie).
//  FSM: IDLE -> ACCESS -> DONE -> IDLE; one access per 3 cycles.
//  IDLE: if neither req, stay. If one req, grant it. If both, grant the port != last_grant.
//   On the transition edge: latch grant_id; load ram_en=1, ram_write_en/addr/write_data from
//   the winner; last_grant=winner.
//  ACCESS (1 cycle): RAM sees the registered command; a write commits at the closing edge.
//   On the closing edge: clear all RAM outputs to 0. If the command was a read
//   (write_en==0), copy ram_read_data into the winner's read_data reg. If it was a write,
//   the winner's read_data reg becomes 0. Assert the winner's ack.
//  DONE (1 cycle): winner's ack=1, other ack=0. On the closing edge, ack -> 0 and go to IDLE.
//  Latency: req sampled in IDLE at edge N -> RAM driven cycle N..N+1 -> ack high in cycle
//   after edge N+1, low after edge N+2.
//  Requester protocol: req and command are held until ack is seen. The requester drops req, or
//   presents a new command, on the edge after ack. Any req seen in IDLE is a new request.
//  req changes while a command is latched (ACCESS/DONE) are ignored; the latched copy is used.
//  Round robin: last_grant only updates on a grant. A lone requester is granted back-to-back
//   regardless of last_grant.
//  Non-granted read_data regs are never disturbed.
//  Async rst mid-ACCESS: RAM outputs clear immediately, so no write commits. No ack is issued.
//   The requester must re-issue after reset.
//  Both acks are never high in the same cycle. ram_en is high only in ACCESS.
// TESTING
//  1 Preload RAM[0x10]=0xDEADBEEF; m0 read 0x10 -> ram_en high 1 cycle; m0_ack 3 cycles
//    after req; m0_read_data=0xDEADBEEF.
//  2 m1 write 0x20, write_en=4'b0010, data=0x0000AB00; then m1 read 0x20
//    -> byte1=0xAB, other bytes unchanged; m1_read_data=0 after the write ack.
//  3 m0 and m1 both req every cycle from reset -> grants alternate m0,m1,m0,m1; acks never overlap.
//  4 m0 alone issues 3 consecutive reads -> 3 grants, 3 cycles apart, all to m0; m1_ack stays 0.
//  5 Assert rst during ACCESS of m1 write 0x30=0x12345678 -> outputs 0 immediately; no ack;
//    RAM[0x30] unchanged.
//  6 m0 read ack, then m1 write -> m0_read_data holds its value through the m1 transaction.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin sequencer in front of a single-port data RAM
module ram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic [SEL_WIDTH-1:0]  m0_write_en,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_write_data,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_read_data,
  input  logic                  m1_req,
  input  logic [SEL_WIDTH-1:0]  m1_write_en,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_write_data,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_read_data,
  output logic                  ram_en,
  output logic [SEL_WIDTH-1:0]  ram_write_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  input  logic [DATA_WIDTH-1:0] ram_read_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t r_state;
  logic r_grant;
  logic r_last;
  logic w_any;
  logic w_win;
  logic [SEL_WIDTH-1:0]  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wd;
  logic [DATA_WIDTH-1:0] w_rd;
  // Pick the winner: a contested slot goes to the port that did not win last time
  always_comb begin
    w_any  = m0_req | m1_req;
    w_win  = (m0_req & m1_req) ? ~r_last : m1_req;
    w_we   = w_win ? m1_write_en : m0_write_en;
    w_addr = w_win ? m1_addr : m0_addr;
    w_wd   = w_win ? m1_write_data : m0_write_data;
    w_rd   = (ram_write_en == '0) ? ram_read_data : '0;
  end
  // IDLE -> ACCESS -> DONE sequencer; RAM command and acks are all registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_grant        <= 1'b0;
      r_last         <= 1'b1;
      ram_en         <= 1'b0;
      ram_write_en   <= '0;
      ram_addr       <= '0;
      ram_write_data <= '0;
      m0_ack         <= 1'b0;
      m1_ack         <= 1'b0;
      m0_read_data   <= '0;
      m1_read_data   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_state        <= ACCESS;
          r_grant        <= w_win;
          r_last         <= w_win;
          ram_en         <= 1'b1;
          ram_write_en   <= w_we;
          ram_addr       <= w_addr;
          ram_write_data <= w_wd;
        end
        ACCESS: begin
          r_state        <= DONE;
          ram_en         <= 1'b0;
          ram_write_en   <= '0;
          ram_addr       <= '0;
          ram_write_data <= '0;
          if (r_grant) begin
            m1_read_data <= w_rd;
            m1_ack       <= 1'b1;
          end else begin
            m0_read_data <= w_rd;
            m0_ack       <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          m0_ack  <= 1'b0;
          m1_ack  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
